// File: rtl/instr_loader.sv
// ---------------------------------------------------------------------------
// instr_loader
//   Front end for the bit-serial CPU core. A 3-wire serial link
//   (ser_clk / ser_data / ser_latch) delivers 16-bit instruction frames MSB
//   first. Each complete frame is buffered in a small FIFO and issued to the
//   core as opcode/instr with a one-cycle inst_done strobe. After each issue
//   the loader waits ISSUE_GAP cycles so the core can execute. The raw step
//   button is debounced into a single-cycle btn_edge pulse.
//
// Ports
//   clk        in   system clock
//   rst_n      in   synchronous active-low reset
//   ser_clk    in   external shift clock (asynchronous)
//   ser_data   in   serial data, sampled on ser_clk rising edge
//   ser_latch  in   frame commit strobe, acted on at its rising edge
//   btn_raw    in   raw push button (asynchronous, bouncy)
//   opcode     out  issued word[15:12]
//   instr      out  issued word[11:0]
//   inst_done  out  1-cycle pulse, opcode/instr are new this cycle
//   btn_edge   out  1-cycle pulse on debounced button press
//   fifo_full  out  FIFO holds FIFO_DEPTH entries
//   fifo_empty out  FIFO holds no entries
//   frame_err  out  1-cycle pulse, latch seen with bit count != 16
//   overflow   out  1-cycle pulse, valid frame dropped because FIFO full
// ---------------------------------------------------------------------------
module instr_loader #(
    parameter int FIFO_DEPTH   = 4,
    parameter int ISSUE_GAP    = 16,
    parameter int DEBOUNCE_CYC = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ser_clk,
    input  logic        ser_data,
    input  logic        ser_latch,
    input  logic        btn_raw,
    output logic [3:0]  opcode,
    output logic [11:0] instr,
    output logic        inst_done,
    output logic        btn_edge,
    output logic        fifo_full,
    output logic        fifo_empty,
    output logic        frame_err,
    output logic        overflow
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int GAP_W = $clog2(ISSUE_GAP + 1);
    localparam int DB_W  = $clog2(DEBOUNCE_CYC + 1);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(ISSUE_GAP - 1);
    localparam logic [DB_W-1:0]  DB_LOAD  = DB_W'(DEBOUNCE_CYC - 1);

    // Bit positions inside the synchronizer vectors
    localparam int IDX_CLK   = 0;
    localparam int IDX_DATA  = 1;
    localparam int IDX_LATCH = 2;
    localparam int IDX_BTN   = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    // ---------------- synchronizers and edge history ----------------
    logic [3:0] sync1_q, sync1_d;
    logic [3:0] sync2_q, sync2_d;
    logic [1:0] hist_q,  hist_d;
    logic       clk_rise;
    logic       latch_rise;
    logic       data_s;
    logic       btn_s;

    // ---------------- serial receiver ----------------
    logic [15:0] shreg_q, shreg_d, shreg_nxt;
    logic [4:0]  bitcnt_q, bitcnt_d, bitcnt_nxt;
    logic        push;
    logic        frame_err_q, frame_err_d;
    logic        overflow_q, overflow_d;

    // ---------------- FIFO ----------------
    logic [15:0]      mem_q [FIFO_DEPTH];
    logic [15:0]      mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic [15:0]      head;

    // ---------------- issue FSM ----------------
    state_t           state_q, state_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [3:0]       opcode_q, opcode_d;
    logic [11:0]      instr_q, instr_d;
    logic             inst_done_q, inst_done_d;
    logic             pop;

    // ---------------- debouncer ----------------
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            level_q, level_d;
    logic            level_hist_q, level_hist_d;
    logic            btn_edge_q, btn_edge_d;

    // All four async inputs share the same two-flop depth so they stay aligned
    always_comb begin
        sync1_d = {btn_raw, ser_latch, ser_data, ser_clk};
        sync2_d = sync1_q;
        hist_d  = {sync2_q[IDX_LATCH], sync2_q[IDX_CLK]};
    end

    assign clk_rise   = sync2_q[IDX_CLK]   & ~hist_q[0];
    assign latch_rise = sync2_q[IDX_LATCH] & ~hist_q[1];
    assign data_s     = sync2_q[IDX_DATA];
    assign btn_s      = sync2_q[IDX_BTN];

    // Shift and commit; a shift in the same cycle as the latch counts toward the frame
    always_comb begin
        shreg_nxt   = shreg_q;
        bitcnt_nxt  = bitcnt_q;
        if (clk_rise) begin
            shreg_nxt = {shreg_q[14:0], data_s};
            if (bitcnt_q != 5'd17) begin
                bitcnt_nxt = bitcnt_q + 5'd1;
            end else begin
                bitcnt_nxt = bitcnt_q;
            end
        end else begin
            shreg_nxt  = shreg_q;
            bitcnt_nxt = bitcnt_q;
        end

        shreg_d     = shreg_nxt;
        bitcnt_d    = bitcnt_nxt;
        push        = 1'b0;
        frame_err_d = 1'b0;
        overflow_d  = 1'b0;
        if (latch_rise) begin
            bitcnt_d = 5'd0;
            if (bitcnt_nxt == 5'd16) begin
                // A pop in this cycle frees a slot even when the FIFO reads full
                if (!full_q || pop) begin
                    push = 1'b1;
                end else begin
                    overflow_d = 1'b1;
                end
            end else begin
                frame_err_d = 1'b1;
            end
        end else begin
            bitcnt_d = bitcnt_nxt;
        end
    end

    assign head = mem_q[rd_ptr_q];

    // FIFO storage, pointers and occupancy; full/empty follow the next count
    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = shreg_nxt;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == FULL_CNT);
        empty_d = (count_d == '0);
    end

    // Issue FSM: pop in IDLE, strobe in ISSUE, wait out the gap in HOLD
    always_comb begin
        state_d     = state_q;
        gap_d       = gap_q;
        opcode_d    = opcode_q;
        instr_d     = instr_q;
        inst_done_d = 1'b0;
        pop         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty_q) begin
                    pop         = 1'b1;
                    opcode_d    = head[15:12];
                    instr_d     = head[11:0];
                    inst_done_d = 1'b1;
                    state_d     = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                gap_d   = GAP_LOAD;
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (gap_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Debounce: level flips only after DEBOUNCE_CYC consecutive differing cycles
    always_comb begin
        level_d      = level_q;
        db_cnt_d     = db_cnt_q;
        level_hist_d = level_q;
        if (btn_s == level_q) begin
            db_cnt_d = DB_LOAD;
        end else if (db_cnt_q == '0) begin
            level_d  = ~level_q;
            db_cnt_d = DB_LOAD;
        end else begin
            db_cnt_d = db_cnt_q - DB_W'(1);
        end
        btn_edge_d = level_q & ~level_hist_q;
    end

    // Synchronizer and edge-history registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 4'b0000;
            sync2_q <= 4'b0000;
            hist_q  <= 2'b00;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            hist_q  <= hist_d;
        end
    end

    // Serial receiver registers and error pulses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg_q     <= 16'h0000;
            bitcnt_q    <= 5'd0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            shreg_q     <= shreg_d;
            bitcnt_q    <= bitcnt_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
        end
    end

    // FIFO registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 16'h0000;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Issue FSM state and issued-word registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            gap_q       <= '0;
            opcode_q    <= 4'h0;
            instr_q     <= 12'h000;
            inst_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            gap_q       <= gap_d;
            opcode_q    <= opcode_d;
            instr_q     <= instr_d;
            inst_done_q <= inst_done_d;
        end
    end

    // Debouncer registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            db_cnt_q     <= DB_LOAD;
            level_q      <= 1'b0;
            level_hist_q <= 1'b0;
            btn_edge_q   <= 1'b0;
        end else begin
            db_cnt_q     <= db_cnt_d;
            level_q      <= level_d;
            level_hist_q <= level_hist_d;
            btn_edge_q   <= btn_edge_d;
        end
    end

    assign opcode     = opcode_q;
    assign instr      = instr_q;
    assign inst_done  = inst_done_q;
    assign btn_edge   = btn_edge_q;
    assign fifo_full  = full_q;
    assign fifo_empty = empty_q;
    assign frame_err  = frame_err_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_instr_loader.sv
// ---------------------------------------------------------------------------
// tb_instr_loader
//   Scoreboard bench for instr_loader. Stimulus tasks push the words the link
//   should deliver into exp_q; a monitor on the falling clock edge pops and
//   compares whenever inst_done is seen, and checks opcode/instr hold their
//   value otherwise. ISSUE_GAP is set large so a whole burst of serial frames
//   fits inside one gap and the FIFO can be filled.
// ---------------------------------------------------------------------------
module tb_instr_loader;

    localparam int DEPTH = 4;
    localparam int GAP   = 250;
    localparam int DB    = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ser_clk = 1'b0;
    logic        ser_data = 1'b0;
    logic        ser_latch = 1'b0;
    logic        btn_raw = 1'b0;
    logic [3:0]  opcode;
    logic [11:0] instr;
    logic        inst_done;
    logic        btn_edge;
    logic        fifo_full;
    logic        fifo_empty;
    logic        frame_err;
    logic        overflow;

    instr_loader #(
        .FIFO_DEPTH   (DEPTH),
        .ISSUE_GAP    (GAP),
        .DEBOUNCE_CYC (DB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ser_clk    (ser_clk),
        .ser_data   (ser_data),
        .ser_latch  (ser_latch),
        .btn_raw    (btn_raw),
        .opcode     (opcode),
        .instr      (instr),
        .inst_done  (inst_done),
        .btn_edge   (btn_edge),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .frame_err  (frame_err),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] exp_q [$];
    int          done_cyc_q [$];
    logic [15:0] last_word = 16'h0000;
    logic [15:0] mon_w;
    int          exp_ferr = 0;
    int          got_ferr = 0;
    int          exp_ovf = 0;
    int          got_ovf = 0;
    int          exp_edges = 0;
    int          got_edges = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (inst_done) begin
                done_cyc_q.push_back(cyc);
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_issue: got %h, expected no issue (cycle %0d)", {opcode, instr}, cyc);
                end else begin
                    mon_w = exp_q.pop_front();
                    if ({opcode, instr} !== mon_w) begin
                        miscompares++;
                        $display("FAIL issue_word: got %h, expected %h (cycle %0d)", {opcode, instr}, mon_w, cyc);
                    end
                    last_word = mon_w;
                end
            end else begin
                check("hold_word", {16'h0000, opcode, instr}, {16'h0000, last_word});
            end
            if (frame_err) got_ferr++;
            if (overflow)  got_ovf++;
            if (btn_edge)  got_edges++;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Shift the low n bits of v MSB first; optionally raise latch with the last clock rise
    task automatic shift_bits(input logic [31:0] v, input int n, input bit merge);
        for (int i = n - 1; i >= 0; i--) begin
            ser_data = v[i];
            ser_clk  = 1'b0;
            tick();
            ser_clk = 1'b1;
            if (i == 0 && merge) ser_latch = 1'b1;
            tick();
        end
    endtask

    // Send one frame and record what the link should produce
    task automatic send_frame(input logic [31:0] v, input int n, input bit merge, input bit expect_ovf);
        if (n == 16) begin
            if (expect_ovf) exp_ovf++;
            else            exp_q.push_back(v[15:0]);
        end else begin
            exp_ferr++;
        end
        shift_bits(v, n, merge && (n > 0));
        if (!(merge && (n > 0))) begin
            ser_latch = 1'b1;
            tick();
        end
        tick();
        ser_latch = 1'b0;
        tick();
        tick();
    endtask

    task automatic wait_drain(input string name, input int max_cyc);
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < max_cyc) begin
            tick();
            i++;
        end
        check(name, exp_q.size(), 0);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    initial begin
        int buffered;
        int seen;
        int target;
        int n;
        logic [31:0] v;

        // ---------------- reset state ----------------
        idle(3);
        check("rst_opcode", opcode, 0);
        check("rst_instr", instr, 0);
        check("rst_inst_done", inst_done, 0);
        check("rst_btn_edge", btn_edge, 0);
        check("rst_fifo_full", fifo_full, 0);
        check("rst_fifo_empty", fifo_empty, 1);
        check("rst_frame_err", frame_err, 0);
        check("rst_overflow", overflow, 0);
        rst_n = 1'b1;
        idle(2);

        // ---------------- debounce ----------------
        for (int r = 0; r < 12; r++) begin
            btn_raw = 1'b1;
            idle($urandom_range(1, 3));
            btn_raw = 1'b0;
            idle($urandom_range(1, 4));
        end
        idle(12);
        check("chatter_no_edge", got_edges, exp_edges);
        btn_raw = 1'b1;
        seen = -1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (btn_edge && seen < 0) seen = i;
        end
        exp_edges++;
        check("btn_edge_latency", seen, DB + 3);
        check("btn_press_one_edge", got_edges, exp_edges);
        btn_raw = 1'b0;
        idle(30);
        check("btn_release_no_edge", got_edges, exp_edges);

        // ---------------- single frame ----------------
        send_frame(32'h8A53, 16, 1'b0, 1'b0);
        wait_drain("drain_8a53", 20);
        tick();
        check("empty_after_issue", fifo_empty, 1);
        check("no_frame_err", got_ferr, exp_ferr);
        check("no_overflow", got_ovf, exp_ovf);

        // ---------------- bad frame lengths ----------------
        send_frame(32'h7FFF, 15, 1'b0, 1'b0);
        check("frame_err_15", got_ferr, exp_ferr);
        send_frame(32'h1234, 16, 1'b0, 1'b0);
        send_frame(32'h1ABCD, 17, 1'b0, 1'b0);
        check("frame_err_17", got_ferr, exp_ferr);
        send_frame(32'h0, 0, 1'b0, 1'b0);
        check("frame_err_0", got_ferr, exp_ferr);
        send_frame(32'hC3A5, 16, 1'b1, 1'b0);
        check("merged_latch_ok", got_ferr, exp_ferr);
        wait_drain("drain_len", 3 * (GAP + 2) + 50);
        idle(GAP + 5);

        // ---------------- fill, overflow, push+pop when full ----------------
        done_cyc_q.delete();
        buffered = 0;
        for (int f = 1; f <= 6; f++) begin
            if (f == 1) begin
                send_frame(f, 16, 1'b0, 1'b0);
            end else if (buffered < DEPTH) begin
                buffered++;
                send_frame(f, 16, 1'b0, 1'b0);
            end else begin
                send_frame(f, 16, 1'b0, 1'b1);
            end
            if (f == 5) check("fifo_full_after_fill", fifo_full, 1);
        end
        check("overflow_on_6th", got_ovf, exp_ovf);
        shift_bits(32'h0007, 16, 1'b0);
        exp_q.push_back(16'h0007);
        target = done_cyc_q[0] + GAP - 1;
        check("timing_budget", (cyc < target) ? 1 : 0, 1);
        while (cyc < target) tick();
        ser_latch = 1'b1;
        tick();
        tick();
        ser_latch = 1'b0;
        tick();
        check("full_after_pushpop", fifo_full, 1);
        check("no_overflow_pushpop", got_ovf, exp_ovf);
        wait_drain("drain_fill", 6 * (GAP + 2) + 50);
        check("issue_count_fill", done_cyc_q.size(), 6);
        for (int i = 1; i < 6 && i < done_cyc_q.size(); i++) begin
            check("issue_spacing", done_cyc_q[i] - done_cyc_q[i-1], GAP + 2);
        end
        idle(GAP + 5);

        // ---------------- reset mid-frame, mid-hold ----------------
        send_frame(32'hA001, 16, 1'b0, 1'b0);
        send_frame(32'hA002, 16, 1'b0, 1'b0);
        send_frame(32'hA003, 16, 1'b0, 1'b0);
        shift_bits(32'h5A, 8, 1'b0);
        rst_n = 1'b0;
        ser_clk = 1'b0;
        ser_data = 1'b0;
        tick();
        exp_q.delete();
        last_word = 16'h0000;
        check("mid_rst_opcode", opcode, 0);
        check("mid_rst_instr", instr, 0);
        check("mid_rst_inst_done", inst_done, 0);
        check("mid_rst_fifo_full", fifo_full, 0);
        check("mid_rst_fifo_empty", fifo_empty, 1);
        check("mid_rst_frame_err", frame_err, 0);
        check("mid_rst_overflow", overflow, 0);
        idle(3);
        rst_n = 1'b1;
        idle(2);
        send_frame(32'hF00F, 16, 1'b0, 1'b0);
        wait_drain("drain_after_rst", 20);
        idle(GAP + 5);

        // ---------------- randomized bursts ----------------
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 3; k++) begin
                v = $urandom;
                case ($urandom_range(0, 3))
                    0, 1:    n = 16;
                    2:       n = 15;
                    default: n = 17;
                endcase
                send_frame(v, n, 1'($urandom_range(0, 1)), 1'b0);
            end
            wait_drain("drain_random", 3 * (GAP + 2) + 50);
            idle(GAP + 5);
        end

        check("final_frame_err", got_ferr, exp_ferr);
        check("final_overflow", got_ovf, exp_ovf);
        check("final_btn_edges", got_edges, exp_edges);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
